// File: rtl/simon_pkg.sv
// Shared constants, state encoding and tone helpers for the Simon audio stage.
package simon_pkg;

  localparam int unsigned F_LAMP0 = 415;
  localparam int unsigned F_LAMP1 = 310;
  localparam int unsigned F_LAMP2 = 252;
  localparam int unsigned F_LAMP3 = 209;
  localparam int unsigned F_BUZZ  = 42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAMP,
    ST_LOSE,
    ST_JINGLE
  } state_t;

  // Clock cycles per half period of a square wave at freq_hz (truncating).
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned freq_hz);
    return clk_hz / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: starts high on restart, toggles every half_last+1 cycles.
module tone_gen #(
  parameter int HW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          enable,
  input  logic [HW-1:0] half_last,
  output logic          spk
);

  logic [HW-1:0] cnt;

  // NOTE: asynchronous reset so the speaker goes silent the moment rst_n drops,
  // and non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      spk <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      spk <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      spk <= 1'b1;
    end else if (cnt == half_last) begin
      cnt <= '0;
      spk <= ~spk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/simon_sound.sv
// Simon audio stage: lamp tones, one-shot loss buzz and high-score jingle on one pin.
module simon_sound
  import simon_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned LOSE_MS = 1500,
  parameter int unsigned NOTE_MS = 150
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       LOSE,
  input  logic       HS,
  output logic       SPK,
  output logic       SPK_ACTIVE
);

  localparam int unsigned MS      = CLK_HZ / 1000;
  localparam int unsigned HALF_L0 = half_period(CLK_HZ, F_LAMP0);
  localparam int unsigned HALF_L1 = half_period(CLK_HZ, F_LAMP1);
  localparam int unsigned HALF_L2 = half_period(CLK_HZ, F_LAMP2);
  localparam int unsigned HALF_L3 = half_period(CLK_HZ, F_LAMP3);
  localparam int unsigned HALF_BZ = half_period(CLK_HZ, F_BUZZ);
  localparam int unsigned DUR_MAX = (LOSE_MS > NOTE_MS) ? LOSE_MS : NOTE_MS;

  localparam int HW = (HALF_BZ > 1) ? $clog2(HALF_BZ) : 1;
  localparam int PW = (MS > 1) ? $clog2(MS) : 1;
  localparam int DW = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  // The tone generator is fed terminal counts (HALF-1), which always fit in HW bits.
  localparam logic [HW-1:0] LAST_L0 = HW'(HALF_L0 - 1);
  localparam logic [HW-1:0] LAST_L1 = HW'(HALF_L1 - 1);
  localparam logic [HW-1:0] LAST_L2 = HW'(HALF_L2 - 1);
  localparam logic [HW-1:0] LAST_L3 = HW'(HALF_L3 - 1);
  localparam logic [HW-1:0] LAST_BZ = HW'(HALF_BZ - 1);

  function automatic logic [HW-1:0] lamp_last(input logic [1:0] code);
    case (code)
      2'd0:    return LAST_L0;
      2'd1:    return LAST_L1;
      2'd2:    return LAST_L2;
      default: return LAST_L3;
    endcase
  endfunction

  state_t          state, next_state;
  logic            lose_q, hs_q;
  logic [1:0]      lamp_q;
  logic [PW-1:0]   pre_cnt;
  logic [DW-1:0]   ms_cnt;
  logic [1:0]      note, note_next;

  logic            lose_rise, hs_rise, busy, ms_tick, dur_done, dur_start;
  logic [DW-1:0]   dur_last;
  logic            tone_restart, tone_en;
  logic [HW-1:0]   tone_last;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    lose_rise = LOSE & ~lose_q;
    hs_rise   = HS & ~hs_q;
    busy      = (state == ST_LOSE) || (state == ST_JINGLE);
    ms_tick   = busy && (pre_cnt == PW'(MS - 1));
    dur_last  = (state == ST_JINGLE) ? DW'(NOTE_MS - 1) : DW'(LOSE_MS - 1);
    dur_done  = ms_tick && (ms_cnt == dur_last);

    next_state = state;
    if (lose_rise) begin
      next_state = ST_LOSE;
    end else begin
      case (state)
        ST_IDLE:   if (hs_rise) next_state = ST_JINGLE;
                   else if (LAMP_ENA) next_state = ST_LAMP;
        ST_LAMP:   if (hs_rise) next_state = ST_JINGLE;
                   else if (!LAMP_ENA) next_state = ST_IDLE;
        ST_LOSE:   if (dur_done) next_state = ST_IDLE;
        ST_JINGLE: if (dur_done && note == 2'd3) next_state = ST_IDLE;
        default:   next_state = ST_IDLE;
      endcase
    end

    // A repeated LOSE edge restarts the buzz even though the state is unchanged.
    dur_start = lose_rise || (next_state == ST_JINGLE && state != ST_JINGLE);

    note_next = note;
    if (dur_start)                            note_next = 2'd0;
    else if (state == ST_JINGLE && dur_done)  note_next = note + 2'd1;

    tone_restart = dur_start
                || (next_state != state)
                || (state == ST_LAMP && next_state == ST_LAMP && LAMP != lamp_q)
                || (state == ST_JINGLE && next_state == ST_JINGLE && dur_done);
    tone_en = (next_state != ST_IDLE);

    tone_last = '0;
    case (next_state)
      ST_LAMP:   tone_last = lamp_last(LAMP);
      ST_LOSE:   tone_last = LAST_BZ;
      ST_JINGLE: tone_last = lamp_last(~note_next);  // notes run lamp 3 down to lamp 0
      default:   tone_last = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      lose_q     <= 1'b0;
      hs_q       <= 1'b0;
      lamp_q     <= 2'd0;
      SPK_ACTIVE <= 1'b0;
    end else begin
      state      <= next_state;
      lose_q     <= LOSE;
      hs_q       <= HS;
      lamp_q     <= LAMP;
      SPK_ACTIVE <= tone_en;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
      note    <= 2'd0;
    end else begin
      note <= note_next;
      if (dur_start || !busy) begin
        pre_cnt <= '0;
        ms_cnt  <= '0;
      end else if (ms_tick) begin
        pre_cnt <= '0;
        ms_cnt  <= dur_done ? '0 : ms_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  tone_gen #(.HW(HW)) u_tone (
    .clk       (CLK),
    .rst_n     (RST_N),
    .restart   (tone_restart),
    .enable    (tone_en),
    .half_last (tone_last),
    .spk       (SPK)
  );

endmodule

// File: tb/tb_simon_sound.sv
// Directed bench for simon_sound at CLK_HZ=100_000 (MS=100); loss and note
// durations are shortened so the whole run stays short.
module tb_simon_sound;

  localparam int unsigned CLK_HZ  = 100_000;
  localparam int unsigned LOSE_MS = 100;   // 10_000-cycle buzz
  localparam int unsigned NOTE_MS = 50;    // 5_000-cycle notes
  localparam int BUZZ_CYC = 10_000;
  localparam int NOTE_CYC = 5_000;
  localparam int BUDGET   = 20_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] lamp;
  logic       lamp_ena, lose, hs;
  logic       spk, spk_active;

  int checks = 0;
  int errors = 0;

  simon_sound #(.CLK_HZ(CLK_HZ), .LOSE_MS(LOSE_MS), .NOTE_MS(NOTE_MS)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .LAMP       (lamp),
    .LAMP_ENA   (lamp_ena),
    .LOSE       (lose),
    .HS         (hs),
    .SPK        (spk),
    .SPK_ACTIVE (spk_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_len(input logic level, output int len);
    len = 0;
    while (spk === level && len < BUDGET) begin
      len++;
      tick();
    end
  endtask

  task automatic active_len(output int len);
    len = 0;
    while (spk_active === 1'b1 && len < BUDGET) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int len, tot, bad;
    int halves [4];
    halves = '{239, 198, 161, 120};

    rst_n = 1'b0; lamp = 2'd0; lamp_ena = 1'b0; lose = 1'b0; hs = 1'b0;
    #1;
    check("reset spk", spk, 0);
    check("reset active", spk_active, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle spk", spk, 0);
    check("idle active", spk_active, 0);

    // Lamp 0 tone: alternating 120-cycle halves.
    lamp = 2'd0; lamp_ena = 1'b1;
    tick();
    check("lamp0 start spk", spk, 1);
    check("lamp0 active", spk_active, 1);
    for (int i = 0; i < 4; i++) begin
      run_len(1'b1, len); check("lamp0 high", len, 120);
      run_len(1'b0, len); check("lamp0 low", len, 120);
    end
    repeat (50) tick();
    lamp_ena = 1'b0;
    tick();
    check("lamp stop spk", spk, 0);
    check("lamp stop active", spk_active, 0);

    // Code change while playing restarts at the new pitch.
    lamp = 2'd0; lamp_ena = 1'b1;
    tick();
    run_len(1'b1, len); check("lamp0 high b", len, 120);
    repeat (10) tick();
    check("lamp0 mid low", spk, 0);
    lamp = 2'd3;
    tick();
    check("lamp3 restart spk", spk, 1);
    run_len(1'b1, len); check("lamp3 high", len, 239);
    run_len(1'b0, len); check("lamp3 low", len, 239);

    // Asynchronous reset mid-tone.
    check("pre-reset spk", spk, 1);
    rst_n = 1'b0;
    #1;
    check("async reset spk", spk, 0);
    check("async reset active", spk_active, 0);
    lamp_ena = 1'b0; lamp = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset idle", spk_active, 0);

    // Loss buzz with LAMP_ENA raised partway through.
    lose = 1'b1;
    tick();
    lose = 1'b0;
    check("buzz start spk", spk, 1);
    check("buzz active", spk_active, 1);
    run_len(1'b1, len); check("buzz high", len, 1190);
    run_len(1'b0, len); check("buzz low", len, 1190);
    lamp = 2'd1; lamp_ena = 1'b1;
    active_len(len);
    check("buzz length", len + 2380, BUZZ_CYC);
    check("buzz end idle active", spk_active, 0);
    check("buzz end idle spk", spk, 0);
    tick();
    check("lamp after buzz spk", spk, 1);
    check("lamp after buzz active", spk_active, 1);
    run_len(1'b1, len); check("lamp1 high", len, 161);
    lamp_ena = 1'b0;
    tick();
    check("lamp1 stop", spk_active, 0);

    // High-score jingle compared cycle by cycle against the expected waveform.
    hs = 1'b1;
    tick();
    hs = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bad = 0;
      for (int t = 0; t < NOTE_CYC; t++) begin
        if (spk !== (((t / halves[n]) % 2) == 0) || spk_active !== 1'b1) bad++;
        tick();
      end
      check($sformatf("jingle note %0d bad cycles", n), bad, 0);
    end
    check("jingle end active", spk_active, 0);
    check("jingle end spk", spk, 0);

    // Loss edge mid-jingle preempts it.
    hs = 1'b1;
    tick();
    hs = 1'b0;
    repeat (3000) tick();
    lose = 1'b1;
    tick();
    lose = 1'b0;
    check("midjingle buzz spk", spk, 1);
    check("midjingle buzz active", spk_active, 1);
    run_len(1'b1, len); check("midjingle buzz high", len, 1190);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous edges: buzz only, no jingle afterwards.
    lose = 1'b1; hs = 1'b1;
    tick();
    lose = 1'b0; hs = 1'b0;
    check("both buzz active", spk_active, 1);
    run_len(1'b1, len); check("both buzz high", len, 1190);
    active_len(tot);
    check("both buzz length", tot + 1190, BUZZ_CYC);
    bad = 0;
    for (int t = 0; t < 300; t++) begin
      if (spk_active !== 1'b0 || spk !== 1'b0) bad++;
      tick();
    end
    check("no jingle after both", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_sound.md
# simon_sound

Audio stage downstream of the Simon game controller. Consumes the controller's lamp code/enable, lose flag and high-score flag, and drives a single square-wave speaker pin: per-lamp tones while a lamp is lit, a one-shot low buzz on loss, and a four-note jingle on a new high score. It sits beside the lamp decoder in the top level and drives one spare `uo_out` pin.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency. All half-periods and the 1 ms tick derive from it by integer division, truncating.
- `LOSE_MS`, 1500, buzz duration in ms.
- `NOTE_MS`, 150, duration of each jingle note in ms.

Ports:
- `CLK` in 1: system clock. One clock domain only.
- `RST_N` in 1: reset, asynchronous, active-low.
- `LAMP` in 2: lamp code from the controller (0..3).
- `LAMP_ENA` in 1: lamp lit.
- `LOSE` in 1: controller lose flag (level).
- `HS` in 1: controller high-score flag (level).
- `SPK` out 1: speaker square wave.
- `SPK_ACTIVE` out 1: high whenever a tone is playing.

## Operation
- Tone frequencies:
  - Lamp 0: 415 Hz.
  - Lamp 1: 310 Hz.
  - Lamp 2: 252 Hz.
  - Lamp 3: 209 Hz.
  - Buzz: 42 Hz.
- Half-period derivation: HALF = CLK_HZ/(2*f). MS = CLK_HZ/1000.
- FSM states:
  - IDLE: SPK=0.
  - LAMP: tone given by the current `LAMP`.
  - LOSE: buzz for LOSE_MS.
  - JINGLE: notes lamp3, lamp2, lamp1, lamp0, NOTE_MS each.
- Edge detection: rising edges of `LOSE`/`HS` come from registered copies of the inputs. The copies reset to 0, so an input already high at reset release counts as an edge.
- Transition priority, evaluated every cycle:
  1. A LOSE rising edge goes to LOSE from any state, restarting the buzz if already in LOSE.
  2. An HS rising edge goes to JINGLE from IDLE or LAMP only. It is ignored in LOSE and JINGLE.
  3. `LAMP_ENA`=1 in IDLE goes to LAMP.
  4. `LAMP_ENA`=0 in LAMP goes to IDLE.
- Simultaneous LOSE and HS rising edges: LOSE wins; the HS edge is discarded.
- LOSE and JINGLE are one-shot. On completion go to IDLE, regardless of input levels. `LAMP_ENA` is ignored during both.
- `LAMP` code change while in LAMP: restart the tone at the new pitch.
- Tone generator, on every tone start (state entry, note change, code change):
  - SPK=1 and half counter cleared.
  - SPK toggles and the counter clears when the counter equals HALF-1.
  - Result: high HALF cycles, then low HALF cycles.
- ms prescaler: runs only in LOSE/JINGLE and clears on entry to either. Duration counters count ms ticks.
- Outputs in IDLE: SPK=0, SPK_ACTIVE=0.
- Reset values: state IDLE, SPK=0, SPK_ACTIVE=0, all counters 0.
- Reset asserted mid-tone: outputs drop to 0 immediately (asynchronous).

## Timing
- Latency: an input event in cycle N takes effect at the clock edge ending cycle N. SPK and SPK_ACTIVE are registered, so they are 1 from cycle N+1.
- Lamp tone stop: `LAMP_ENA` falling in cycle N gives SPK=0 from cycle N+1, even mid-half-period.
- LOSE duration: exactly LOSE_MS×MS cycles, with SPK_ACTIVE=1 throughout.
- JINGLE duration: exactly 4×NOTE_MS×MS cycles.
- Counter widths: half counter is $clog2 of the largest HALF (buzz; 20 bits at 50 MHz). Duration and prescaler counters are sized from their parameters. No wrap is possible in normal operation.

## Structure
- Shared package `simon_pkg`:
  - Tone frequency constants.
  - State enum (IDLE, LAMP, LOSE, JINGLE).
  - Helper function computing HALF from CLK_HZ and f.
- Sub-module `tone_gen`:
  - Inputs: restart strobe, HALF value, enable.
  - Output: square wave.
- The FSM and duration counting stay in simon_sound.

## Test plan
All scenarios use CLK_HZ=100_000, giving MS=100, HALF0=120, HALF1=161, HALF2=198, HALF3=239, buzz HALF=1190.
- Reset with all inputs 0:
  - SPK=0 and SPK_ACTIVE=0.
  - Assert RST_N low mid-tone → both outputs 0 immediately.
- LAMP=0, LAMP_ENA=1 for 1000 cycles:
  - SPK high 120 cycles then low 120 cycles, repeating.
  - Drop LAMP_ENA → SPK=0 on the next cycle.
- While lamp 0 plays, change LAMP to 3 → SPK=1 next cycle, then high 239 / low 239.
- Pulse LOSE high one cycle:
  - Buzz with 1190-cycle halves, SPK_ACTIVE=1 for exactly 150_000 cycles, then idle.
  - LAMP_ENA=1 during the buzz → ignored until the buzz ends, then lamp tone the next cycle.
- HS rising edge:
  - Notes with halves 239, 198, 161, 120, 15_000 cycles each, then idle.
  - LOSE rising mid-jingle → buzz starts next cycle.
- LOSE and HS rising in the same cycle → buzz only, no jingle afterwards.
